taxi_axi_ram_resp: RTL
======================

TAXI_AXI_RAM_RESP -- requirements
Module: taxi_axi_ram_resp

Interface
REQ-001 SHALL have parameter MEM_ADDR_W, default 16: number of implemented byte-address bits; memory size is 2**MEM_ADDR_W bytes.
REQ-002 SHALL have parameter PIPELINE_OUTPUT, default 0: when 1, adds one register stage on R (rdata, rid, rlast), raising read latency by 1 cycle.
REQ-003 SHALL take DATA_W, ADDR_W, STRB_W and ID_W from the connected taxi_axi_if; DATA_W is 8, 16, 32, 64, 128, 256 or 512; STRB_W equals DATA_W/8; MEM_ADDR_W is at most ADDR_W.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port s_axi_wr, taxi_axi_if write-slave modport: AW, W and B channels.
REQ-007 SHALL have port s_axi_rd, taxi_axi_if read-slave modport: AR and R channels.

Function
REQ-008 SHALL act as an AXI4 responder backed by a byte-addressed RAM; word index is addr[MEM_ADDR_W-1:log2(STRB_W)]; address bits at and above MEM_ADDR_W are ignored (aliasing).
REQ-009 SHALL run independent write and read FSMs; reads and writes proceed concurrently.
REQ-010 Write FSM states: IDLE (awready=1), DATA (wready=1), RESP (bvalid=1).
REQ-011 IDLE->DATA on AW handshake; captures awid, awaddr, awlen, awsize, awburst; wready asserts the next cycle.
REQ-012 In DATA, each W handshake SHALL write only the byte lanes with wstrb set, then advance the address; after awlen+1 beats, go to RESP the next cycle.
REQ-013 Beat count SHALL end the write burst; wlast is ignored; extra W beats are not accepted until the next AW.
REQ-014 RESP SHALL drive bid = captured awid and bresp = OKAY (2'b00); on bready, go to IDLE; awready reasserts the next cycle.
REQ-015 Read FSM states: IDLE (arready=1) and BURST (R beats outstanding); capture on AR handshake mirrors the write side.
REQ-016 With PIPELINE_OUTPUT=0, rvalid SHALL assert the cycle after the AR handshake; rid = arid; rresp = OKAY.
REQ-017 rvalid SHALL stay high through the burst with no bubbles: after each R handshake, the next beat's data is presented the next cycle.
REQ-018 rlast SHALL assert on beat arlen+1 only; the R handshake on that beat returns to IDLE.
REQ-019 rdata, rid and rlast SHALL hold stable while rvalid=1 and rready=0.
REQ-020 Address advance SHALL follow the burst type: FIXED = no change; INCR = add 1<<size; WRAP = add 1<<size within the region of size (len+1)<<size aligned to that size, wrapping to its base; reserved burst type 2'b11 behaves as INCR.
REQ-021 Narrow transfers (size < log2(STRB_W)) SHALL use the full data bus; the master's wstrb selects lanes on writes; reads return the whole word.
REQ-022 An unaligned INCR start address SHALL be aligned down to the transfer size after the first beat.
REQ-023 Same-cycle write beat and read to the same word SHALL return the pre-write data.
REQ-024 awlock and arlock SHALL be treated as normal accesses; EXOKAY is never returned; cache, prot, qos and user signals are ignored; buser and ruser are driven 0.

Reset
REQ-025 While rst=1: awready, wready, bvalid, arready and rvalid are 0; bid, rid, rlast and rdata are 0; both FSMs are in IDLE.
REQ-026 awready and arready SHALL rise the first cycle after rst deasserts.
REQ-027 rst asserted mid-burst SHALL abandon the burst with no B or R completion; bytes already written stay written.
REQ-028 RAM contents SHALL NOT be reset.

Verification
REQ-029 INCR write: AW addr 0x100, len 3, size 2, id 0x5A; W 0x11111111..0x44444444 with strobe 0xF -> one B with bid 0x5A, OKAY; then AR at the same address returns the 4 words with rlast on beat 4.
REQ-030 Strobes: write 0xAABBCCDD with wstrb 0b0101 over 0x00000000 at 0x200 -> readback 0x00BB00DD.
REQ-031 WRAP read: AR addr 0x10C, len 3, size 2 -> beats read 0x10C, 0x100, 0x104, 0x108.
REQ-032 Backpressure: rready toggled 1,0,0,1 during an 8-beat read, plus bready held low 5 cycles -> data stable during stalls, no lost or duplicated beats, exactly one B.
REQ-033 Concurrent traffic: 16-beat write and 16-beat read to disjoint regions -> both complete with correct data; rvalid continuous with rready=1.
REQ-034 Reset mid-write after 2 of 4 beats -> no B, awready=1 the cycle after reset, and a new burst completes normally.

Source files
------------

// File: rtl/taxi_axi_ram_resp_if.sv
// AXI4 bundle shared by the RAM responder and its masters.
// Write/read slave and master modports; widths set by parameters.
interface taxi_axi_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int STRB_W = DATA_W / 8,
   parameter int ID_W   = 8,
   parameter int USER_W = 1
) ();
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awlock;
   logic [3:0]        awcache;
   logic [2:0]        awprot;
   logic [3:0]        awqos;
   logic [USER_W-1:0] awuser;
   logic              awvalid;
   logic              awready;

   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wlast;
   logic [USER_W-1:0] wuser;
   logic              wvalid;
   logic              wready;

   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic [USER_W-1:0] buser;
   logic              bvalid;
   logic              bready;

   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic [3:0]        arqos;
   logic [USER_W-1:0] aruser;
   logic              arvalid;
   logic              arready;

   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [USER_W-1:0] ruser;
   logic              rvalid;
   logic              rready;

   modport wr_slv (
      input  awid, awaddr, awlen, awsize, awburst, awlock,
      input  awcache, awprot, awqos, awuser, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wuser, wvalid,
      output wready,
      output bid, bresp, buser, bvalid,
      input  bready
   );

   modport rd_slv (
      input  arid, araddr, arlen, arsize, arburst, arlock,
      input  arcache, arprot, arqos, aruser, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, ruser, rvalid,
      input  rready
   );

   modport wr_mst (
      output awid, awaddr, awlen, awsize, awburst, awlock,
      output awcache, awprot, awqos, awuser, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wuser, wvalid,
      input  wready,
      input  bid, bresp, buser, bvalid,
      output bready
   );

   modport rd_mst (
      output arid, araddr, arlen, arsize, arburst, arlock,
      output arcache, arprot, arqos, aruser, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, ruser, rvalid,
      output rready
   );
endinterface

// File: rtl/taxi_axi_ram_resp.sv
// AXI4 RAM responder: independent write (AW/W/B) and read (AR/R) FSMs.
// Ports: clk, rst (sync, active-high), s_axi_wr (wr_slv), s_axi_rd (rd_slv).
module taxi_axi_ram_resp #(
   parameter int MEM_ADDR_W      = 16,
   parameter bit PIPELINE_OUTPUT = 1'b0
) (
   input logic        clk,
   input logic        rst,
   taxi_axi_if.wr_slv s_axi_wr,
   taxi_axi_if.rd_slv s_axi_rd
);
   localparam int DATA_W   = s_axi_wr.DATA_W;
   localparam int ADDR_W   = s_axi_wr.ADDR_W;
   localparam int STRB_W   = s_axi_wr.STRB_W;
   localparam int ID_W     = s_axi_wr.ID_W;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = MEM_ADDR_W - ADDR_LSB;
   localparam int WORDS    = 1 << IDX_W;

   logic [DATA_W-1:0] mem [WORDS];

   function automatic logic [ADDR_W-1:0] next_addr(
      input logic [ADDR_W-1:0] addr,
      input logic [2:0]        size,
      input logic [1:0]        burst,
      input logic [7:0]        len
   );
      logic [ADDR_W-1:0] step;
      logic [ADDR_W-1:0] mask;
      step = ADDR_W'(1) << size;
      mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      unique case (burst)
         2'b00:   return addr;
         2'b10:   return (addr & ~mask) | ((addr + step) & mask);
         // INCR and reserved: align down, then step
         default: return (addr & ~(step - ADDR_W'(1))) + step;
      endcase
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
      return a[MEM_ADDR_W-1:ADDR_LSB];
   endfunction

   // ---------------- write side ----------------
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

   wr_state_t         wr_state_q, wr_state_d;
   logic [ID_W-1:0]   wid_q, wid_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wlen_q, wlen_d;
   logic [7:0]        wcnt_q, wcnt_d;
   logic [2:0]        wsize_q, wsize_d;
   logic [1:0]        wburst_q, wburst_d;
   logic              awready, wready, bvalid, wr_en;

   always_comb begin
      wr_state_d = wr_state_q;
      wid_d      = wid_q;
      waddr_d    = waddr_q;
      wlen_d     = wlen_q;
      wcnt_d     = wcnt_q;
      wsize_d    = wsize_q;
      wburst_d   = wburst_q;
      awready    = 1'b0;
      wready     = 1'b0;
      bvalid     = 1'b0;
      wr_en      = 1'b0;
      unique case (wr_state_q)
         W_IDLE: begin
            awready = !rst;
            if (awready && s_axi_wr.awvalid) begin
               wid_d      = s_axi_wr.awid;
               waddr_d    = s_axi_wr.awaddr;
               wlen_d     = s_axi_wr.awlen;
               wcnt_d     = s_axi_wr.awlen;
               wsize_d    = s_axi_wr.awsize;
               wburst_d   = s_axi_wr.awburst;
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            wready = !rst;
            if (wready && s_axi_wr.wvalid) begin
               wr_en   = 1'b1;
               waddr_d = next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
               wcnt_d  = wcnt_q - 8'd1;
               // beat count, not wlast, closes the burst
               if (wcnt_q == 8'd0) wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            bvalid = !rst;
            if (bvalid && s_axi_wr.bready) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         wid_q      <= '0;
         waddr_q    <= '0;
         wlen_q     <= '0;
         wcnt_q     <= '0;
         wsize_q    <= '0;
         wburst_q   <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         wid_q      <= wid_d;
         waddr_q    <= waddr_d;
         wlen_q     <= wlen_d;
         wcnt_q     <= wcnt_d;
         wsize_q    <= wsize_d;
         wburst_q   <= wburst_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (s_axi_wr.wstrb[i])
               mem[idx(waddr_q)][8*i +: 8] <= s_axi_wr.wdata[8*i +: 8];
         end
      end
   end

   assign s_axi_wr.awready = awready;
   assign s_axi_wr.wready  = wready;
   assign s_axi_wr.bvalid  = bvalid;
   assign s_axi_wr.bid     = bvalid ? wid_q : '0;
   assign s_axi_wr.bresp   = 2'b00;
   assign s_axi_wr.buser   = '0;

   // ---------------- read side ----------------
   typedef enum logic {R_IDLE, R_BURST} rd_state_t;

   rd_state_t         rd_state_q, rd_state_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [7:0]        rlen_q, rlen_d;
   logic [7:0]        rcnt_q, rcnt_d;
   logic [2:0]        rsize_q, rsize_d;
   logic [1:0]        rburst_q, rburst_d;
   logic              rlast_q, rlast_d;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] rd_addr;
   logic              arready, rd_en, c_valid, c_ready;

   always_comb begin
      rd_state_d = rd_state_q;
      rid_d      = rid_q;
      raddr_d    = raddr_q;
      rlen_d     = rlen_q;
      rcnt_d     = rcnt_q;
      rsize_d    = rsize_q;
      rburst_d   = rburst_q;
      rlast_d    = rlast_q;
      rd_addr    = raddr_q;
      arready    = 1'b0;
      rd_en      = 1'b0;
      c_valid    = 1'b0;
      unique case (rd_state_q)
         R_IDLE: begin
            arready = !rst;
            if (arready && s_axi_rd.arvalid) begin
               rid_d      = s_axi_rd.arid;
               raddr_d    = s_axi_rd.araddr;
               rlen_d     = s_axi_rd.arlen;
               rcnt_d     = s_axi_rd.arlen;
               rsize_d    = s_axi_rd.arsize;
               rburst_d   = s_axi_rd.arburst;
               rlast_d    = (s_axi_rd.arlen == 8'd0);
               rd_addr    = s_axi_rd.araddr;
               rd_en      = 1'b1;
               rd_state_d = R_BURST;
            end
         end
         R_BURST: begin
            c_valid = !rst;
            if (c_valid && c_ready) begin
               if (rlast_q) begin
                  rd_state_d = R_IDLE;
               end else begin
                  // fetch the next beat now so rvalid never bubbles
                  raddr_d = next_addr(raddr_q, rsize_q, rburst_q, rlen_q);
                  rd_addr = raddr_d;
                  rd_en   = 1'b1;
                  rcnt_d  = rcnt_q - 8'd1;
                  rlast_d = (rcnt_q == 8'd1);
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         rid_q      <= '0;
         raddr_q    <= '0;
         rlen_q     <= '0;
         rcnt_q     <= '0;
         rsize_q    <= '0;
         rburst_q   <= '0;
         rlast_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rid_q      <= rid_d;
         raddr_q    <= raddr_d;
         rlen_q     <= rlen_d;
         rcnt_q     <= rcnt_d;
         rsize_q    <= rsize_d;
         rburst_q   <= rburst_d;
         rlast_q    <= rlast_d;
         // read before any same-edge write lands: old data wins
         if (rd_en) rdata_q <= mem[idx(rd_addr)];
      end
   end

   logic              o_valid;
   logic [DATA_W-1:0] o_data;
   logic [ID_W-1:0]   o_id;
   logic              o_last;

   if (PIPELINE_OUTPUT) begin : g_pipe
      logic              ov_q;
      logic [DATA_W-1:0] od_q;
      logic [ID_W-1:0]   oid_q;
      logic              ol_q;

      assign c_ready = !ov_q || s_axi_rd.rready;

      always_ff @(posedge clk) begin
         if (rst) begin
            ov_q  <= 1'b0;
            od_q  <= '0;
            oid_q <= '0;
            ol_q  <= 1'b0;
         end else if (c_ready) begin
            ov_q  <= c_valid;
            od_q  <= rdata_q;
            oid_q <= rid_q;
            ol_q  <= rlast_q;
         end
      end

      assign o_valid = ov_q && !rst;
      assign o_data  = od_q;
      assign o_id    = oid_q;
      assign o_last  = ol_q;
   end else begin : g_direct
      assign c_ready = s_axi_rd.rready;
      assign o_valid = c_valid;
      assign o_data  = rdata_q;
      assign o_id    = rid_q;
      assign o_last  = rlast_q;
   end

   assign s_axi_rd.arready = arready;
   assign s_axi_rd.rvalid  = o_valid;
   assign s_axi_rd.rdata   = rst ? '0 : o_data;
   assign s_axi_rd.rid     = rst ? '0 : o_id;
   assign s_axi_rd.rlast   = rst ? 1'b0 : o_last;
   assign s_axi_rd.rresp   = 2'b00;
   assign s_axi_rd.ruser   = '0;

   // sideband fields accepted but intentionally ignored
   logic unused_sig;
   assign unused_sig = ^{s_axi_wr.awlock, s_axi_wr.awcache,
                         s_axi_wr.awprot, s_axi_wr.awqos,
                         s_axi_wr.awuser, s_axi_wr.wlast,
                         s_axi_wr.wuser, s_axi_rd.arlock,
                         s_axi_rd.arcache, s_axi_rd.arprot,
                         s_axi_rd.arqos, s_axi_rd.aruser};
endmodule
